// File: rtl/seg_pkg.sv
// Shared constants, types and anode decoding for the seven-segment scan capture.
package seg_pkg;

  localparam logic [3:0] AN_NONE    = 4'b1111;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  // What a settled scan slot turned out to be when it was sampled.
  typedef enum logic [1:0] {
    SLOT_IDLE,   // no sample this cycle, or a blanking slot
    SLOT_VALID,  // exactly one anode active
    SLOT_MULTI   // two or more anodes active at once
  } slot_kind_t;

  typedef struct packed {
    logic       valid;  // exactly one low bit
    logic       multi;  // two or more low bits
    digit_idx_t idx;    // position of the low bit when valid
  } an_dec_t;

  // Decode an active-low anode vector into {valid, multi, idx}.
  function automatic an_dec_t an_decode(input logic [3:0] an_n);
    an_dec_t     r;
    int unsigned lows;
    r    = '0;
    lows = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        lows  = lows + 1;
        r.idx = digit_idx_t'(i);
      end
    end
    r.valid = (lows == 1);
    r.multi = (lows >= 2);
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Two back-to-back flops to resolve metastability of asynchronous inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive side of a multiplexed seven-segment bus: waits for each scan slot
// to settle, captures its segment pattern per digit and publishes all four
// digits together when a full frame has been seen.
module sseg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic       frame_done,
  output logic       err_an,
  output logic       stale
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic [11:0] s2;
  logic [3:0]  s2_an;
  logic [7:0]  s2_sseg;

  sync2 #(
    .WIDTH   (12),
    .RST_VAL ({AN_NONE, SSEG_BLANK})
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    ({an, sseg}),
    .q_o    (s2)
  );

  assign s2_an   = s2[11:8];
  assign s2_sseg = s2[7:0];

  // ---------------------------------------------------------------------------
  // Stability counter
  // ---------------------------------------------------------------------------
  logic [11:0]      prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample_evt;

  // Restart on any change, count matching cycles up to saturation; the sample
  // fires on the single transition into saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (s2 != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
    sample_evt = (s2 == prev_q) && (cnt_q == CNT_FIRE);
  end

  // Keep last synced value and the running stable count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= {AN_NONE, SSEG_BLANK};
      cnt_q  <= '0;
    end else begin
      prev_q <= s2;
      cnt_q  <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot classification
  // ---------------------------------------------------------------------------
  an_dec_t    dec;
  slot_kind_t kind;

  // Decide what the settled slot represents only at the sample event.
  always_comb begin
    dec  = an_decode(s2_an);
    kind = SLOT_IDLE;
    if (sample_evt) begin
      if (dec.multi) begin
        kind = SLOT_MULTI;
      end else if (dec.valid) begin
        kind = SLOT_VALID;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow capture, frame publication and timeout
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [3:0][7:0] dout_q, dout_d;
  logic [3:0]      seen_q, seen_d, seen_set;
  logic [TO_W-1:0] to_q, to_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;

  // A valid sample takes priority over the timeout in the same cycle, so the
  // timeout branch is only evaluated when no digit was captured.
  always_comb begin
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    seen_set     = seen_q;
    seen_d       = seen_q;
    to_d         = to_q;
    stale_d      = stale_q;
    frame_done_d = 1'b0;
    err_d        = (kind == SLOT_MULTI);

    if (kind == SLOT_VALID) begin
      shadow_d[dec.idx] = s2_sseg;
      seen_set[dec.idx] = 1'b1;
    end
    seen_d = seen_set;

    if (kind == SLOT_VALID) begin
      to_d    = '0;
      stale_d = 1'b0;
      if (&seen_set) begin
        dout_d       = shadow_d;
        frame_done_d = 1'b1;
        seen_d       = '0;
      end
    end else begin
      if (to_q != TO_LIMIT) begin
        to_d = to_q + 1'b1;
      end
      if (to_d == TO_LIMIT) begin
        stale_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  // Capture and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= {NUM_DIGITS{SSEG_BLANK}};
      dout_q       <= {NUM_DIGITS{SSEG_BLANK}};
      seen_q       <= '0;
      to_q         <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      seen_q       <= seen_d;
      to_q         <= to_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      stale_q      <= stale_d;
    end
  end

  assign d0         = dout_q[0];
  assign d1         = dout_q[1];
  assign d2         = dout_q[2];
  assign d3         = dout_q[3];
  assign frame_done = frame_done_q;
  assign err_an     = err_q;
  assign stale      = stale_q;

endmodule
